serial_latch_loader: RTL
========================

# serial_latch_loader

Serial-to-parallel front end for the transparent D-latch bank. It collects a framed serial bit stream into a WIDTH-bit word. When the word is complete it presents the word on a registered parallel bus and drives a one-cycle enable pulse that opens the downstream latches. The latches then hold that word until the next load.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, bit order: 1 = first serial bit lands in par_q[WIDTH-1]; 0 = first serial bit lands in par_q[0].

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame-start strobe, sampled on clk.
- sdi  input  1  serial data bit.
- sdi_valid  input  1  sdi qualifier; a bit is accepted only on a cycle where this is 1.
- busy  output  1  high while a frame is being assembled (SHIFT state).
- par_q  output  WIDTH  last completed word; registered; drives the D inputs of the latches.
- latch_en  output  1  one-cycle pulse; drives the en input of the latches.
- frame_err  output  1  one-cycle pulse indicating a frame was aborted by a new start.

## Operation
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - busy=0, par_q=0, latch_en=0, frame_err=0.
  - Shift register and bit counter are cleared.
- The state machine has three states: IDLE, SHIFT, LOAD.
- IDLE:
  - sdi_valid without start is ignored.
  - start=1 moves to SHIFT with the counter set to 0.
  - If sdi_valid=1 on the same cycle as start, that bit is accepted as bit 0, and the counter becomes 1.
- SHIFT:
  - Each cycle with sdi_valid=1 shifts sdi into the shift register and increments the counter.
  - Gaps in sdi_valid stall the frame indefinitely. There is no timeout.
  - When the bit accepted is bit WIDTH-1, the next state is LOAD.
- LOAD (exactly one cycle):
  - latch_en=1.
  - par_q takes the assembled word on the same edge that enters LOAD.
  - The next state is IDLE. If start=1 in this cycle, the next state is SHIFT instead, so back-to-back frames need no idle gap; a coincident valid bit is accepted as bit 0.
- start during SHIFT aborts the current frame:
  - frame_err pulses for one cycle.
  - par_q is unchanged and latch_en does not fire.
  - The counter restarts at 0; a coincident valid bit is accepted as bit 0 of the new frame.
- Bit order:
  - MSB_FIRST=1: shift left, inserting at bit 0.
  - MSB_FIRST=0: shift right, inserting at bit WIDTH-1.
- The counter width is $clog2(WIDTH+1). The counter never wraps because it is cleared at LOAD and at start.
- par_q holds its value between LOADs. It changes only on the edge entering LOAD.

## Timing
- Latency: last bit accepted at edge N → par_q updated and latch_en=1 during cycle N..N+1 → latch_en=0 after edge N+1.
- par_q is stable for the whole latch_en-high cycle and after it, so the latches close on stable data.
- busy:
  - Rises on the edge after start is accepted.
  - Falls on the edge entering LOAD.
  - Stays high through an abort-restart.
- frame_err is registered: high for the one cycle following the aborting start edge.
- Reset asserted mid-frame clears everything immediately. No latch_en is produced for the partial word.
- The first frame after release needs a fresh start.
- Minimum frame period is WIDTH+1 cycles, or WIDTH cycles when start overlaps LOAD.

## Structure
- Shared package serial_latch_pkg:
  - state_t enum {IDLE, SHIFT, LOAD}.
  - Bit-order constants.
- Single module, with no sub-module. The downstream latch bank is instantiated by the parent, not inside this block.

## Test plan
- MSB-first 0xA5: WIDTH=8, MSB_FIRST=1, start + bits 1,0,1,0,0,1,0,1 on consecutive cycles → par_q=8'hA5, latch_en high exactly one cycle, one clock after the last bit, and busy low afterwards.
- LSB-first: MSB_FIRST=0, bits 0,0,0,1,1,1,1,0 → par_q=8'h78.
- Abort: preload par_q=8'hA5; start, 3 bits, start again, then 8 bits of 0x0F (MSB first) → frame_err one cycle with par_q still 0xA5 and no latch_en; then par_q=8'h0F with a single latch_en.
- Stalled frame plus stray bits:
  - Random 0–3 cycle gaps in sdi_valid within a 0xC3 frame → par_q=8'hC3, with latch_en only after the 8th valid bit.
  - sdi_valid in IDLE without start → no state change.
- Back-to-back and reset:
  - start asserted in the LOAD cycle → the second word is loaded WIDTH cycles later, with two distinct latch_en pulses.
  - rst_n low after 5 bits → all outputs 0 immediately, and no latch_en after release.

Source files
------------

// File: rtl/serial_latch_pkg.sv
// serial_latch_pkg
//   Shared definitions for the serial-to-parallel latch loader:
//   - state_t    : loader FSM states (IDLE, SHIFT, LOAD)
//   - ORDER_*    : bit-order selectors for the MSB_FIRST parameter
package serial_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam bit ORDER_MSB_FIRST = 1'b1;  // first serial bit ends in par_q[WIDTH-1]
  localparam bit ORDER_LSB_FIRST = 1'b0;  // first serial bit ends in par_q[0]

endpackage

// File: rtl/serial_latch_loader.sv
// serial_latch_loader
//   Collects a framed serial bit stream into a WIDTH-bit word, then presents
//   it on a registered parallel bus together with a one-cycle latch enable
//   for a downstream transparent latch bank.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   frame-start strobe (also aborts a frame in progress)
//   sdi        in   serial data bit
//   sdi_valid  in   sdi qualifier
//   busy       out  high while a frame is being assembled
//   par_q      out  last completed word (registered)
//   latch_en   out  one-cycle pulse on the cycle par_q takes a new word
//   frame_err  out  one-cycle pulse after a frame was aborted by start
//
// Handshake: sdi_valid is a pure qualifier with no back-pressure. A bit is
// taken on every rising edge where sdi_valid=1 and the loader is either in
// SHIFT or sees start on that same edge; otherwise the bit is dropped.
module serial_latch_loader
  import serial_latch_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             busy,
  output logic [WIDTH-1:0] par_q,
  output logic             latch_en,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Current FSM state, kept as a named signal so checkers can bind to it.
  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [WIDTH-1:0] par_n;
  logic             latch_en_n;
  logic             frame_err_n;
  logic [WIDTH-1:0] shifted;

  // Shift register with the incoming bit inserted on the entry side.
  always_comb begin
    shifted = shreg;
    if (MSB_FIRST) begin
      shifted = {shreg[WIDTH-2:0], sdi};
    end else begin
      shifted = {sdi, shreg[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    par_n       = par_q;
    latch_en_n  = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      // LOAD behaves like IDLE for its single cycle, which lets a start in
      // the LOAD cycle open the next frame without an idle gap.
      IDLE, LOAD: begin
        state_n = IDLE;
        if (start) begin
          state_n = SHIFT;
          cnt_n   = sdi_valid ? CW'(1) : '0;
          if (sdi_valid) begin
            shreg_n = shifted;
          end
        end
      end

      SHIFT: begin
        if (start) begin
          // Abort: restart the count; old shift contents get pushed out by
          // the new frame's bits, so they need no explicit clear.
          frame_err_n = 1'b1;
          cnt_n       = sdi_valid ? CW'(1) : '0;
          if (sdi_valid) begin
            shreg_n = shifted;
          end
        end else if (sdi_valid) begin
          shreg_n = shifted;
          if (cnt == LAST_BIT) begin
            state_n    = LOAD;
            cnt_n      = '0;
            par_n      = shifted;
            latch_en_n = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      par_q     <= '0;
      latch_en  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      par_q     <= par_n;
      latch_en  <= latch_en_n;
      frame_err <= frame_err_n;
    end
  end

  assign busy = (state == SHIFT);

endmodule
